// File: rtl/rtmq_uart_pkg.sv
// -----------------------------------------------------------------------------
// rtmq_uart_pkg
// Shared definitions for the RTMQ UART host bridge: the default idle
// instruction, Tx/Rx state encodings, a constant clog2 helper and the
// Rx frame length derivation.
// Optional feature macro: RTMQ_UART_CKSUM_EN (adds a trailing XOR checksum
// byte to every Rx frame, which changes the frame length).
// -----------------------------------------------------------------------------
package rtmq_uart_pkg;

    // Instruction presented on cfg_ins whenever no frame is being delivered.
    localparam int unsigned I_NOP_DEF = 0;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Ceiling log2 usable in parameter/port-width expressions.
    function automatic int clog2(input int unsigned v);
        int          r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Bytes per Rx frame: instruction bytes, one flag byte, optional checksum.
    function automatic int n_rx(input int w_reg);
`ifdef RTMQ_UART_CKSUM_EN
        return w_reg / 8 + 2;
`else
        return w_reg / 8 + 1;
`endif
    endfunction

endpackage

// File: rtl/rtmq_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// rtmq_uart_tx_fifo
// Synchronous word FIFO buffering core-side words for the UART transmitter.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push/push_dat write request and word; dropped when full unless a pop
//                 happens in the same cycle
//   pop/pop_dat   read request; pop_dat shows the head word combinationally
//   empty, full   occupancy flags
//   lvl           current occupancy (0..DEPTH)
//   ovf           sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module rtmq_uart_tx_fifo
    import rtmq_uart_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            push_dat,
    input  logic                    pop,
    output logic [W-1:0]            pop_dat,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   lvl,
    output logic                    ovf
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (lvl == (AW+1)'(DEPTH));
    assign empty   = (lvl == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the head slot, so a push into a full
    // FIFO is still accepted then.
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and level define
    // validity, which keeps the RAM free of a reset network.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            ovf    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   lvl <= lvl + 1'b1;
                2'b01:   lvl <= lvl - 1'b1;
                default: lvl <= lvl;
            endcase
            if (push && !push_ok) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/rtmq_uart_bridge.sv
// -----------------------------------------------------------------------------
// rtmq_uart_bridge
// UART host bridge for the RTMQ core.
//   Tx: words from the core are buffered in a FIFO and sent LSB byte first,
//       each byte as start, 8 data bits LSB first, N_STB stop bits.
//   Rx: (W_REG+8)-bit frames from the host become a one-cycle instruction
//       on cfg_ins plus a persistent override flag f_cfg.
// Optional feature macro: RTMQ_UART_CKSUM_EN -- frames carry one extra
// trailing byte, the XOR of all preceding bytes; mismatching frames are
// dropped and reported through rx_err.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tx_dat, tx_wr       word and push strobe into the Tx FIFO
//   tx_full, tx_lvl     Tx FIFO full flag and occupancy
//   tx_ovf              sticky Tx FIFO overflow flag
//   f_tx_done           one-cycle pulse after the last stop bit of a word
//   cfg_ins, cfg_vld    received instruction (I_NOP when idle) and its strobe
//   f_cfg               override flag of the last accepted frame
//   rx_err, err_cnt     framing/timeout/checksum error pulse, saturating count
//   uart_rx, uart_tx    serial lines
// -----------------------------------------------------------------------------
module rtmq_uart_bridge
    import rtmq_uart_pkg::*;
#(
    parameter int               W_REG    = 32,
    parameter int               DIV      = 868,
    parameter int               N_STB    = 1,
    parameter int               TX_DEPTH = 8,
    parameter int               S_TOT    = 17,
    parameter logic [W_REG-1:0] I_NOP    = W_REG'(I_NOP_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W_REG-1:0]           tx_dat,
    input  logic                       tx_wr,
    output logic                       tx_full,
    output logic [clog2(TX_DEPTH):0]   tx_lvl,
    output logic                       tx_ovf,
    output logic                       f_tx_done,
    output logic [W_REG-1:0]           cfg_ins,
    output logic                       f_cfg,
    output logic                       cfg_vld,
    output logic                       rx_err,
    output logic [7:0]                 err_cnt,
    input  logic                       uart_rx,
    output logic                       uart_tx
);

    localparam int CW    = clog2(DIV);
    localparam int NB    = W_REG / 8;
    localparam int BW    = clog2(NB + 1);
    localparam int N_RX  = n_rx(W_REG);
    localparam int RBW   = clog2(N_RX + 1);
    localparam int FW    = (N_RX - 1) * 8;     // bytes held before the last one
    localparam int TW    = clog2(S_TOT * DIV + 1);

    localparam logic [CW-1:0]  DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF_M1  = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0]  TX_LAST  = BW'(NB - 1);
    localparam logic [RBW-1:0] RX_LAST  = RBW'(N_RX - 1);
    localparam logic           STB_LAST = 1'(N_STB - 1);
    localparam logic [TW-1:0]  TO_M1    = TW'(S_TOT * DIV - 1);

    // ------------------------------------------------------------------ Tx
    logic [W_REG-1:0] fifo_dat;
    logic             fifo_empty;
    logic             tx_pop;
    logic             tx_tick;
    logic             tx_word_end;

    tx_state_t        tx_state;
    logic [CW-1:0]    tx_cnt;
    logic [2:0]       tx_bit;
    logic [BW-1:0]    tx_byte;
    logic             tx_stb;
    logic [W_REG-1:0] tx_sh;

    rtmq_uart_tx_fifo #(
        .W     (W_REG),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_wr),
        .push_dat (tx_dat),
        .pop      (tx_pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .full     (tx_full),
        .lvl      (tx_lvl),
        .ovf      (tx_ovf)
    );

    assign tx_tick     = (tx_cnt == DIV_M1);
    assign tx_word_end = (tx_state == TX_STOP) && tx_tick &&
                         (tx_stb == STB_LAST) && (tx_byte == TX_LAST);
    // Popping at the end of a word lets the next start bit follow the last
    // stop bit directly, with no idle gap between words.
    assign tx_pop      = !fifo_empty && ((tx_state == TX_IDLE) || tx_word_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_byte   <= '0;
            tx_stb    <= 1'b0;
            tx_sh     <= '0;
            uart_tx   <= 1'b1;
            f_tx_done <= 1'b0;
        end else begin
            // NOTE: pulse outputs get a default at the top of the block and
            // are overridden below, so each is high for exactly one cycle.
            f_tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_sh    <= fifo_dat;
                        tx_byte  <= '0;
                        tx_cnt   <= '0;
                        uart_tx  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_sh[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        // Shifting the whole word leaves the next byte in
                        // the low bits once 8 bits have gone out.
                        tx_sh  <= tx_sh >> 1;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_stb   <= 1'b0;
                            tx_state <= TX_STOP;
                        end else begin
                            uart_tx <= tx_sh[1];
                            tx_bit  <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_stb != STB_LAST) begin
                            tx_stb <= 1'b1;
                        end else if (tx_byte != TX_LAST) begin
                            tx_byte  <= tx_byte + 1'b1;
                            uart_tx  <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            f_tx_done <= 1'b1;
                            if (tx_pop) begin
                                tx_sh    <= fifo_dat;
                                tx_byte  <= '0;
                                uart_tx  <= 1'b0;
                                tx_state <= TX_START;
                            end else begin
                                tx_state <= TX_IDLE;
                            end
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ Rx
    logic           rx_s1;
    logic           rx_s2;
    logic           rx_prev;
    logic           rx_fall;
    logic           rx_tick;
    logic           cks_ok;
    logic           fin_flag;
    logic [7:0]     err_cnt_nx;

    rx_state_t      rx_state;
    logic [CW-1:0]  rx_cnt;
    logic [2:0]     rx_bit;
    logic [RBW-1:0] rx_byte;
    logic [7:0]     rx_sh;
    logic [FW-1:0]  rx_frame;
    logic [TW-1:0]  to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall    = rx_prev && !rx_s2;
    assign rx_tick    = (rx_cnt == DIV_M1);
    assign err_cnt_nx = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

`ifdef RTMQ_UART_CKSUM_EN
    logic [7:0] cks;
    always_comb begin
        cks = '0;
        for (int i = 0; i < N_RX - 1; i++) begin
            cks = cks ^ rx_frame[i*8 +: 8];
        end
    end
    assign cks_ok   = (cks == rx_sh);
    assign fin_flag = rx_frame[W_REG];
`else
    assign cks_ok   = 1'b1;
    // Without a checksum the final byte is the flag byte itself.
    assign fin_flag = rx_sh[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
            rx_sh    <= '0;
            rx_frame <= '0;
            to_cnt   <= '0;
            cfg_ins  <= I_NOP;
            f_cfg    <= 1'b0;
            cfg_vld  <= 1'b0;
            rx_err   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            cfg_ins <= I_NOP;
            cfg_vld <= 1'b0;
            rx_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end else if (rx_byte != '0) begin
                        // Inter-byte timeout, only while a frame is open.
                        if (to_cnt == TO_M1) begin
                            rx_err  <= 1'b1;
                            err_cnt <= err_cnt_nx;
                            rx_byte <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt <= '0;
                        // Line back high at mid start bit: a glitch, ignore.
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_bit   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        to_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (!rx_s2) begin
                            rx_err  <= 1'b1;
                            err_cnt <= err_cnt_nx;
                            rx_byte <= '0;
                        end else if (rx_byte == RX_LAST) begin
                            rx_byte <= '0;
                            if (cks_ok) begin
                                cfg_ins <= rx_frame[W_REG-1:0];
                                f_cfg   <= fin_flag;
                                cfg_vld <= 1'b1;
                            end else begin
                                rx_err  <= 1'b1;
                                err_cnt <= err_cnt_nx;
                            end
                        end else begin
                            // Bytes enter at the top, so byte 0 ends up in
                            // the low bits (little-endian assembly).
                            rx_frame <= FW'({rx_sh, rx_frame} >> 8);
                            rx_byte  <= rx_byte + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtmq_uart_bridge.sv
// -----------------------------------------------------------------------------
// tb_rtmq_uart_bridge
// Scoreboard bench for rtmq_uart_bridge (W_REG=32, DIV=4, N_STB=1,
// TX_DEPTH=4, S_TOT=17). Stimulus pushes expected Tx bytes and Rx frames
// into queues; independent monitors decode uart_tx and watch cfg_vld and
// compare against the queue heads.
// -----------------------------------------------------------------------------
module tb_rtmq_uart_bridge;

    localparam int          W_REG    = 32;
    localparam int          DIV      = 4;
    localparam int          N_STB    = 1;
    localparam int          TX_DEPTH = 4;
    localparam int          S_TOT    = 17;
    localparam logic [31:0] NOP      = 32'h0;

    logic        clk;
    logic        rst;
    logic [31:0] tx_dat;
    logic        tx_wr;
    logic        tx_full;
    logic [2:0]  tx_lvl;
    logic        tx_ovf;
    logic        f_tx_done;
    logic [31:0] cfg_ins;
    logic        f_cfg;
    logic        cfg_vld;
    logic        rx_err;
    logic [7:0]  err_cnt;
    logic        uart_rx;
    logic        uart_tx;

    typedef struct packed {
        logic [31:0] ins;
        logic        flag;
    } cfg_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         err_seen = 0;
    logic [7:0] tx_exp[$];
    cfg_t       cfg_exp[$];
    int         done_cyc[$];

    rtmq_uart_bridge #(
        .W_REG    (W_REG),
        .DIV      (DIV),
        .N_STB    (N_STB),
        .TX_DEPTH (TX_DEPTH),
        .S_TOT    (S_TOT),
        .I_NOP    (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_dat    (tx_dat),
        .tx_wr     (tx_wr),
        .tx_full   (tx_full),
        .tx_lvl    (tx_lvl),
        .tx_ovf    (tx_ovf),
        .f_tx_done (f_tx_done),
        .cfg_ins   (cfg_ins),
        .f_cfg     (f_cfg),
        .cfg_vld   (cfg_vld),
        .rx_err    (rx_err),
        .err_cnt   (err_cnt),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitors
    // Decode the Tx line: start detected on the first low negedge sample,
    // then each bit sampled near its middle.
    initial begin : tx_mon
        logic [7:0] b;
        logic       stop_b;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                aborted = 0;
                repeat (DIV + 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    if (rst) aborted = 1;
                    b[i] = uart_tx;
                    repeat (DIV) @(negedge clk);
                end
                if (rst) aborted = 1;
                stop_b = uart_tx;
                if (!aborted) begin
                    check("tx stop bit", stop_b, 1);
                    if (tx_exp.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx unexpected byte: got 0x%0h, expected none", b);
                    end else begin
                        check("tx byte", b, tx_exp.pop_front());
                    end
                end
            end
        end
    end

    initial begin : cfg_mon
        cfg_t e;
        forever begin
            @(negedge clk);
            if (!rst && cfg_vld) begin
                if (cfg_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cfg unexpected frame: got ins=0x%0h flag=%0b, expected none",
                             cfg_ins, f_cfg);
                end else begin
                    e = cfg_exp.pop_front();
                    check("cfg_ins", cfg_ins, e.ins);
                    check("f_cfg on frame", f_cfg, e.flag);
                    @(negedge clk);
                    check("cfg_ins back to nop", cfg_ins, NOP);
                    check("cfg_vld one cycle", cfg_vld, 0);
                    check("f_cfg held", f_cfg, e.flag);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && f_tx_done) done_cyc.push_back(cyc);
        if (!rst && rx_err)    err_seen++;
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_sent);
        tx_dat = w;
        tx_wr  = 1'b1;
        if (expect_sent) begin
            for (int i = 0; i < 4; i++) tx_exp.push_back(w[i*8 +: 8]);
        end
        tick(1);
        tx_wr = 1'b0;
    endtask

    task automatic rx_bit(input logic v);
        uart_rx = v;
        tick(DIV);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
    endtask

    // Byte 0 of the frame is f[7:0].
    task automatic send_frame(input logic [39:0] f);
        for (int i = 0; i < 5; i++) send_byte(f[i*8 +: 8], 1'b1);
    endtask

    task automatic exp_cfg(input logic [31:0] ins, input logic flag);
        cfg_t e;
        e.ins  = ins;
        e.flag = flag;
        cfg_exp.push_back(e);
    endtask

    task automatic wait_dones(input int n, input int budget);
        int k;
        k = 0;
        while (done_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    logic [31:0] words [6];
    int          t0;
    int          k;
    bit          nop_ok;

    initial begin
        words[0] = 32'h13121110;
        words[1] = 32'h23222120;
        words[2] = 32'h33323130;
        words[3] = 32'h43424140;
        words[4] = 32'h53525150;
        words[5] = 32'h63626160;

        rst     = 1'b1;
        uart_rx = 1'b1;
        tx_wr   = 1'b0;
        tx_dat  = '0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        check("rst uart_tx", uart_tx, 1);
        check("rst cfg_ins", cfg_ins, NOP);
        check("rst f_cfg", f_cfg, 0);
        check("rst cfg_vld", cfg_vld, 0);
        check("rst rx_err", rx_err, 0);
        check("rst err_cnt", err_cnt, 0);
        check("rst tx_ovf", tx_ovf, 0);
        check("rst f_tx_done", f_tx_done, 0);
        check("rst tx_lvl", tx_lvl, 0);
        check("rst tx_full", tx_full, 0);

        // 1. Single word, byte order and word timing
        done_cyc.delete();
        push_word(32'h44332211, 1);
        k = 0;
        while (uart_tx !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        t0 = cyc;
        wait_dones(1, 400);
        tick(20);
        check("t1 done count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check("t1 done latency", done_cyc[0] - t0, 160);
        check("t1 bytes drained", tx_exp.size(), 0);

        // 2. Six back-to-back pushes: four buffered, sixth dropped
        done_cyc.delete();
        for (int i = 0; i < 6; i++) push_word(words[i], i < 5);
        check("t2 tx_lvl", tx_lvl, 4);
        check("t2 tx_full", tx_full, 1);
        check("t2 tx_ovf", tx_ovf, 1);
        wait_dones(5, 1000);
        tick(200);
        check("t2 done count", done_cyc.size(), 5);
        for (int i = 1; i < 5 && i < done_cyc.size(); i++)
            check("t2 word spacing", done_cyc[i] - done_cyc[i-1], 160);
        check("t2 bytes drained", tx_exp.size(), 0);
        check("t2 tx_lvl empty", tx_lvl, 0);
        check("t2 tx_ovf sticky", tx_ovf, 1);

        // 3. Rx frames, flag set then cleared
        exp_cfg(32'h12345678, 1'b1);
        send_frame(40'h01_12345678);
        tick(10);
        check("t3 f_cfg set", f_cfg, 1);
        exp_cfg(32'hDEADBEEF, 1'b0);
        send_frame(40'h00_DEADBEEF);
        tick(10);
        check("t3 f_cfg cleared", f_cfg, 0);
        check("t3 no rx_err", err_seen, 0);

        // 4. One-cycle glitch is ignored
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        tick(12);
        check("t4 glitch no rx_err", err_seen, 0);
        check("t4 glitch err_cnt", err_cnt, 0);
        exp_cfg(32'hDDCCBBAA, 1'b1);
        send_frame(40'h01_DDCCBBAA);
        tick(10);
        check("t4 f_cfg", f_cfg, 1);

        // 5. Partial frame times out
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        nop_ok = 1;
        for (int i = 0; i < 75; i++) begin
            if (cfg_vld !== 1'b0 || cfg_ins !== NOP) nop_ok = 0;
            tick(1);
        end
        check("t5 cfg_ins stays nop", nop_ok, 1);
        check("t5 rx_err pulses", err_seen, 1);
        check("t5 err_cnt", err_cnt, 1);
        check("t5 f_cfg unchanged", f_cfg, 1);
        exp_cfg(32'h04030201, 1'b0);
        send_frame(40'h00_04030201);
        tick(10);
        check("t5 f_cfg after frame", f_cfg, 0);

        // 6a. Framing error
        send_byte(8'h55, 1'b0);
        uart_rx = 1'b1;
        tick(10);
        check("t6 framing rx_err", err_seen, 2);
        check("t6 framing err_cnt", err_cnt, 2);

        // 6b. Reset in the middle of a transmitted byte
        done_cyc.delete();
        push_word(32'hCAFEF00D, 0);
        push_word(32'h0BADBEEF, 0);
        k = 0;
        while (uart_tx !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tick(20);
        check("t6 lvl before rst", tx_lvl, 1);
        rst = 1'b1;
        #1;
        check("t6 rst uart_tx", uart_tx, 1);
        check("t6 rst tx_lvl", tx_lvl, 0);
        check("t6 rst err_cnt", err_cnt, 0);
        check("t6 rst tx_ovf", tx_ovf, 0);
        tick(5);
        rst = 1'b0;
        tick(400);
        check("t6 line idle after rst", uart_tx, 1);
        check("t6 no done after rst", done_cyc.size(), 0);

        check("final tx queue empty", tx_exp.size(), 0);
        check("final cfg queue empty", cfg_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtmq_uart_bridge.md
Name: rtmq_uart_bridge

Overview:
Parametrised UART host bridge for the RTMQ core. Buffers register-width words from the core in a Tx FIFO and serialises them LSB-byte-first. Deserialises (W_REG+8)-bit configuration frames from the host into a one-cycle configuration instruction plus a persistent override flag. Adds over the previous generation: Tx buffering with overflow detection, selectable stop bits, start-bit glitch rejection, framing/timeout error reporting, and an error counter.

Parameters:
W_REG, 32, register/instruction width; multiple of 8, 8..64.
DIV, 868, clock cycles per bit (100 MHz / 115200); minimum 4.
N_STB, 1, stop bits on Tx (1 or 2); Rx always checks exactly one stop bit.
TX_DEPTH, 8, Tx FIFO depth in words; power of 2, minimum 2.
S_TOT, 17, inter-byte timeout on Rx, in bit periods.
I_NOP, 0, value driven on cfg_ins when no frame is being delivered.

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-high.
tx_dat  in  W_REG  word to transmit.
tx_wr  in  1  push tx_dat into the Tx FIFO.
tx_full  out  1  Tx FIFO full.
tx_lvl  out  clog2(TX_DEPTH)+1  current Tx FIFO occupancy.
tx_ovf  out  1  sticky flag: a push was attempted while the FIFO was full.
f_tx_done  out  1  one-cycle pulse at the end of each transmitted word.
cfg_ins  out  W_REG  received instruction; valid for one cycle, otherwise I_NOP.
f_cfg  out  1  configuration override flag; holds its value between frames.
cfg_vld  out  1  one-cycle pulse, coincident with cfg_ins valid.
rx_err  out  1  one-cycle pulse on a framing error or timeout.
err_cnt  out  8  saturating count of rx_err events.
uart_rx  in  1  UART Rx line (asynchronous).
uart_tx  out  1  UART Tx line.

Behaviour:
- Reset values: uart_tx=1, cfg_ins=I_NOP, f_cfg=0, cfg_vld=0, rx_err=0, err_cnt=0, tx_ovf=0, f_tx_done=0, FIFO empty (tx_lvl=0).
- Assertion of rst mid-frame aborts both directions immediately. uart_tx returns to 1 without completing the current byte.

Tx FIFO:
- A push with tx_wr while not full is accepted.
- A push while full is dropped and sets tx_ovf, which stays set until reset.
- A simultaneous push and pop is always legal, including when the FIFO is full; occupancy is unchanged.
- Read/write pointers wrap modulo TX_DEPTH.

Tx FSM states: IDLE, START, DATA, STOP.
- IDLE: when the FIFO is non-empty, pop one word into the shift register and move to START on the next cycle.
- Each word is sent as W_REG/8 bytes, byte 0 first.
- Each byte: start bit 0 for DIV cycles, then 8 data bits LSB first at DIV cycles each, then N_STB stop bits of 1.
- After the last stop bit of the last byte: pulse f_tx_done for one cycle, then return to IDLE.
- Back-to-back words are sent with no extra idle bit.

Rx path:
- uart_rx passes through a 2-flop synchroniser.
- Rx FSM states: IDLE, START, DATA, STOP.
- IDLE: on a falling edge, wait DIV/2 cycles and re-sample. If the line is 1, treat it as a glitch and return to IDLE; no error is raised.
- DATA: sample at mid-bit every DIV cycles, 8 bits, LSB first.
- STOP: a stop sample of 0 is a framing error. Discard the partial frame, pulse rx_err, and return to IDLE.
- Frame length N_RX = W_REG/8+1 bytes, assembled little-endian.
- Timeout: if a frame is partially received and no start bit arrives within S_TOT×DIV cycles of the last stop sample, discard the frame and pulse rx_err.
- On a complete frame, in the cycle after the final stop sample:
  - cfg_ins ← frame[W_REG-1:0]
  - f_cfg ← frame[W_REG]
  - cfg_vld=1
- Next cycle: cfg_ins returns to I_NOP and f_cfg holds its value.
- Frame bits [W_REG+7:W_REG+1] are reserved and ignored.
- err_cnt saturates at 255.

Optional Feature:
- Macro: RTMQ_UART_CKSUM_EN.
- Defined: N_RX = W_REG/8+2. The last byte is the XOR of all preceding frame bytes. On a mismatch: drop the frame, pulse rx_err, increment err_cnt; cfg_ins and f_cfg are unchanged.
- Undefined: no checksum byte; behaviour as above.

Decomposition:
- Package rtmq_uart_pkg holds: I_NOP default, Tx/Rx state encodings, a clog2 function, and the N_RX derivation function.
- One natural sub-module: rtmq_uart_tx_fifo (synchronous FIFO with push/pop/full/level/overflow).
- Baud counters and both FSMs stay in the top module.

Test Plan:
All scenarios use W_REG=32, DIV=4, N_STB=1, TX_DEPTH=4, S_TOT=17.
1. Push 0x44332211 → uart_tx sends bytes 0x11, 0x22, 0x33, 0x44 (10 bits each, 40 cycles per byte); f_tx_done pulses once, 160 cycles after the first start bit.
2. Push 6 words in consecutive cycles while the first is transmitting → FIFO holds 4, the sixth push is dropped, tx_ovf=1; exactly 5 words appear on the line, gap-free.
3. Rx frame bytes 0x78, 0x56, 0x34, 0x12, 0x01 → cfg_ins=0x12345678 with cfg_vld for one cycle, then I_NOP; f_cfg=1 and held. A second frame with top byte 0x00 clears f_cfg.
4. Drive a 1-cycle low glitch on uart_rx → no error; a valid frame afterwards is decoded correctly.
5. Send 2 bytes and then stay idle for 70 cycles → rx_err pulses once, err_cnt=1, cfg_ins stays I_NOP; a following full frame is decoded.
6. Byte with stop bit forced to 0 → rx_err pulses and err_cnt increments. Assert rst mid-Tx → uart_tx=1 and tx_lvl=0 immediately.
